// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle for the weighted round-robin arbiter.
// The master drives requests and weights; the slave returns the grant.
interface weighted_rr_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N-1:0]    last;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            valid;

  modport master (
    output req, last, weight,
    input  gnt, gnt_id, valid
  );

  modport slave (
    input  req, last, weight,
    output gnt, gnt_id, valid
  );
endinterface

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with registered grant.
// Owners hold for up to weight+1 cycles; handoff has no bubble.
module weighted_rr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  weighted_rr_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;

  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] base;
  logic          arb;
  logic [IW:0]   sel;
  logic          rel;

  // Circular search from base; lowest offset wins.
  function automatic logic [IW:0] pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] b
  );
    logic [IW:0] res;
    int          idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(b) + i;
      if (idx >= N) idx = idx - N;
      if (r[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  // gnt_id_q doubles as the owner index while BUSY.
  assign nxt_ptr = (gnt_id_q == IW'(N - 1)) ? '0
                 : gnt_id_q + 1'b1;

  assign rel = !bus.req[gnt_id_q]
            || bus.last[gnt_id_q]
            || (cnt_q == '0);

  assign sel = pick(bus.req, base);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    base     = ptr_q;
    arb      = 1'b0;

    unique case (state_q)
      IDLE: arb = 1'b1;
      BUSY: begin
        if (rel) begin
          arb   = 1'b1;
          base  = nxt_ptr;
          ptr_d = nxt_ptr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase

    if (arb) begin
      if (sel[IW]) begin
        state_d  = BUSY;
        gnt_d    = '0;
        gnt_d[sel[IW-1:0]] = 1'b1;
        gnt_id_d = sel[IW-1:0];
        cnt_d    = bus.weight[int'(sel[IW-1:0])*WW +: WW];
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.valid  = |gnt_q;

endmodule
